// File: rtl/buzzer_sequencer.sv
// Buzzer pattern sequencer: three prioritised requesters, each mapped to a tone and a beep count.
// Optional feature macro: BUZZER_PREEMPT_EN (a higher-priority request aborts the running pattern).
module buzzer_sequencer #(
    parameter int unsigned ON_TICKS  = 4,
    parameter int unsigned OFF_TICKS = 2,
    parameter int unsigned TONE_0    = 4,
    parameter int unsigned TONE_1    = 8,
    parameter int unsigned TONE_2    = 16,
    parameter int unsigned BEEPS_0   = 1,
    parameter int unsigned BEEPS_1   = 2,
    parameter int unsigned BEEPS_2   = 3
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        tick,
    input  logic [2:0]  req,
    output logic        buzz_enable,
    output logic [15:0] freq_select,
    output logic [2:0]  ack,
    output logic        done,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ON   = 2'd1,
        OFF  = 2'd2
    } state_t;

    localparam logic [15:0] ON_LAST  = 16'(ON_TICKS - 1);
    localparam logic [15:0] OFF_LAST = 16'(OFF_TICKS - 1);

    state_t      state;
    logic [2:0]  pending;
    logic [1:0]  sel;
    logic [3:0]  beep_cnt;
    logic [15:0] tick_cnt;

    logic        has_pend;
    logic [1:0]  hi;
    logic        preempt;
    logic        load;
    logic [2:0]  clear_mask;

    function automatic logic [15:0] tone_of(input logic [1:0] idx);
        case (idx)
            2'd2:    tone_of = 16'(TONE_2);
            2'd1:    tone_of = 16'(TONE_1);
            default: tone_of = 16'(TONE_0);
        endcase
    endfunction

    function automatic logic [3:0] beeps_of(input logic [1:0] idx);
        case (idx)
            2'd2:    beeps_of = 4'(BEEPS_2);
            2'd1:    beeps_of = 4'(BEEPS_1);
            default: beeps_of = 4'(BEEPS_0);
        endcase
    endfunction

    always_comb begin
        has_pend = |pending;
        if (pending[2])
            hi = 2'd2;
        else if (pending[1])
            hi = 2'd1;
        else
            hi = 2'd0;
    end

`ifdef BUZZER_PREEMPT_EN
    always_comb preempt = (state != IDLE) && has_pend && (hi > sel);
`else
    always_comb preempt = 1'b0;
`endif

    always_comb begin
        load       = ((state == IDLE) && has_pend) || preempt;
        clear_mask = load ? (3'b001 << hi) : 3'b000;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pending     <= '0;
            sel         <= '0;
            beep_cnt    <= '0;
            tick_cnt    <= '0;
            buzz_enable <= 1'b0;
            freq_select <= '0;
            ack         <= '0;
            done        <= 1'b0;
            busy        <= 1'b0;
        end else begin
            // New requests win over the clear of the index being accepted this edge.
            pending <= (pending & ~clear_mask) | req;
            ack     <= '0;
            done    <= 1'b0;

            if (load) begin
                state       <= ON;
                sel         <= hi;
                beep_cnt    <= beeps_of(hi);
                tick_cnt    <= '0;
                ack         <= clear_mask;
                buzz_enable <= 1'b1;
                freq_select <= tone_of(hi);
                busy        <= 1'b1;
            end else begin
                case (state)
                    ON: begin
                        if (tick) begin
                            if (tick_cnt == ON_LAST) begin
                                tick_cnt    <= '0;
                                state       <= OFF;
                                buzz_enable <= 1'b0;
                            end else begin
                                tick_cnt <= tick_cnt + 16'd1;
                            end
                        end
                    end
                    OFF: begin
                        if (tick) begin
                            if (tick_cnt == OFF_LAST) begin
                                tick_cnt <= '0;
                                beep_cnt <= beep_cnt - 4'd1;
                                if (beep_cnt == 4'd1) begin
                                    state       <= IDLE;
                                    done        <= 1'b1;
                                    busy        <= 1'b0;
                                    freq_select <= '0;
                                end else begin
                                    state       <= ON;
                                    buzz_enable <= 1'b1;
                                end
                            end else begin
                                tick_cnt <= tick_cnt + 16'd1;
                            end
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Directed table-driven bench for buzzer_sequencer at default parameters.
// The preemption expectations follow BUZZER_PREEMPT_EN when it is defined for the build.
module tb_buzzer_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        tick = 1'b0;
    logic [2:0]  req = 3'b000;
    logic        buzz_enable;
    logic [15:0] freq_select;
    logic [2:0]  ack;
    logic        done;
    logic        busy;

    int checks = 0;
    int failures = 0;

    buzzer_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .tick        (tick),
        .req         (req),
        .buzz_enable (buzz_enable),
        .freq_select (freq_select),
        .ack         (ack),
        .done        (done),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        tk;
        logic [2:0]  rq;
        logic        be;
        logic [15:0] fs;
        logic [2:0]  ak;
        logic        dn;
        logic        bs;
    } vec_t;

    vec_t vecs[$];

    task automatic push(input logic tk, input logic [2:0] rq, input logic be,
                        input logic [15:0] fs, input logic [2:0] ak, input logic dn, input logic bs);
        vec_t v;
        v.tk = tk; v.rq = rq; v.be = be; v.fs = fs; v.ak = ak; v.dn = dn; v.bs = bs;
        vecs.push_back(v);
    endtask

    // A whole pattern with tick=1: 4 on rows, 2 off rows per beep, then the done row.
    task automatic push_run(input logic [2:0] ak, input logic [15:0] fs, input int beeps);
        for (int b = 0; b < beeps; b++) begin
            for (int i = 0; i < 4; i++)
                push(1'b1, 3'b000, 1'b1, fs, (b == 0 && i == 0) ? ak : 3'b000, 1'b0, 1'b1);
            for (int i = 0; i < 2; i++)
                push(1'b1, 3'b000, 1'b0, fs, 3'b000, 1'b0, 1'b1);
        end
        push(1'b1, 3'b000, 1'b0, 16'd0, 3'b000, 1'b1, 1'b0);
    endtask

    task automatic check(input string name, input logic [21:0] exp);
        logic [21:0] got;
        got = {buzz_enable, freq_select, ack, done, busy};
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got{be,fs,ack,done,busy}=%h want=%h", name, got, exp);
        end
    endtask

    task automatic step(input logic tk, input logic [2:0] rq);
        tick = tk;
        req  = rq;
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("reset_state", 22'h0);
        rst_n = 1'b1;
        step(1'b1, 3'b000);
        check("idle_after_reset", 22'h0);

        // Single beep on requester 0
        push(1'b1, 3'b001, 1'b0, 16'd0, 3'b000, 1'b0, 1'b0);
        push_run(3'b001, 16'd4, 1);
        // Two beeps on requester 1
        push(1'b1, 3'b010, 1'b0, 16'd0, 3'b000, 1'b0, 1'b0);
        push_run(3'b010, 16'd8, 2);
        // Simultaneous requests: 2 first, then 0 straight after done
        push(1'b1, 3'b101, 1'b0, 16'd0, 3'b000, 1'b0, 1'b0);
        push_run(3'b100, 16'd16, 3);
        push_run(3'b001, 16'd4, 1);
        // Requester 2 arrives on the 2nd on-cycle of requester 0
        push(1'b1, 3'b001, 1'b0, 16'd0, 3'b000, 1'b0, 1'b0);
        push(1'b1, 3'b000, 1'b1, 16'd4, 3'b001, 1'b0, 1'b1);
        push(1'b1, 3'b000, 1'b1, 16'd4, 3'b000, 1'b0, 1'b1);
        push(1'b1, 3'b100, 1'b1, 16'd4, 3'b000, 1'b0, 1'b1);
`ifndef BUZZER_PREEMPT_EN
        push(1'b1, 3'b000, 1'b1, 16'd4, 3'b000, 1'b0, 1'b1);
        push(1'b1, 3'b000, 1'b0, 16'd4, 3'b000, 1'b0, 1'b1);
        push(1'b1, 3'b000, 1'b0, 16'd4, 3'b000, 1'b0, 1'b1);
        push(1'b1, 3'b000, 1'b0, 16'd0, 3'b000, 1'b1, 1'b0);
`endif
        push_run(3'b100, 16'd16, 3);
        // Tick every third cycle: 12 on cycles, 6 off cycles
        push(1'b0, 3'b001, 1'b0, 16'd0, 3'b000, 1'b0, 1'b0);
        push(1'b0, 3'b000, 1'b1, 16'd4, 3'b001, 1'b0, 1'b1);
        for (int i = 0; i <= 10; i++)
            push((i % 3) == 2, 3'b000, 1'b1, 16'd4, 3'b000, 1'b0, 1'b1);
        for (int i = 11; i <= 16; i++)
            push((i % 3) == 2, 3'b000, 1'b0, 16'd4, 3'b000, 1'b0, 1'b1);
        push(1'b1, 3'b000, 1'b0, 16'd0, 3'b000, 1'b1, 1'b0);
        // Tick held low mid-on freezes everything
        push(1'b1, 3'b010, 1'b0, 16'd0, 3'b000, 1'b0, 1'b0);
        push(1'b1, 3'b000, 1'b1, 16'd8, 3'b010, 1'b0, 1'b1);
        push(1'b1, 3'b000, 1'b1, 16'd8, 3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 20; i++)
            push(1'b0, 3'b000, 1'b1, 16'd8, 3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++)
            push(1'b1, 3'b000, 1'b1, 16'd8, 3'b000, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++)
            push(1'b1, 3'b000, 1'b0, 16'd8, 3'b000, 1'b0, 1'b1);
        push_run(3'b000, 16'd8, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            step(vecs[i].tk, vecs[i].rq);
            check($sformatf("vec%0d", i),
                  {vecs[i].be, vecs[i].fs, vecs[i].ak, vecs[i].dn, vecs[i].bs});
        end

        // Asynchronous reset in the off phase with requester 1 pending
        step(1'b1, 3'b001);
        check("rst_seq_req", 22'h0);
        step(1'b1, 3'b000);
        check("rst_seq_ack", {1'b1, 16'd4, 3'b001, 1'b0, 1'b1});
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'b000);
            check("rst_seq_on", {1'b1, 16'd4, 3'b000, 1'b0, 1'b1});
        end
        step(1'b1, 3'b010);
        check("rst_seq_off", {1'b0, 16'd4, 3'b000, 1'b0, 1'b1});
        req = 3'b000;
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_async_clear", 22'h0);
        @(posedge clk);
        #1;
        check("rst_held", 22'h0);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 3'b000);
            check("rst_no_replay", 22'h0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/buzzer_sequencer.md
BUZZER_SEQUENCER -- requirements
Module: buzzer_sequencer

Interface
REQ-001 SHALL have parameter ON_TICKS, default 4, meaning beep-on length in tick strobes (legal 1..65535).
REQ-002 SHALL have parameter OFF_TICKS, default 2, meaning inter-beep silence in tick strobes (legal 1..65535).
REQ-003 SHALL have parameters TONE_0/TONE_1/TONE_2, defaults 4/8/16, meaning 16-bit frequency_select value per requester.
REQ-004 SHALL have parameters BEEPS_0/BEEPS_1/BEEPS_2, defaults 1/2/3, meaning beep count per requester (legal 1..15).
REQ-005 clk  input  1  sole clock; all state on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 tick  input  1  single-cycle time-base strobe, synchronous to clk.
REQ-008 req  input  3  request pulses; req[0] countdown beep, req[1] interval change, req[2] workout complete; req[2] highest priority.
REQ-009 buzz_enable  output  1  drives frequency generator enable.
REQ-010 freq_select  output  16  drives frequency generator period select.
REQ-011 ack  output  3  one-cycle pulse marking acceptance of the matching request.
REQ-012 done  output  1  one-cycle pulse marking completion of a pattern.
REQ-013 busy  output  1  high whenever state is not IDLE.

Function
REQ-014 SHALL latch each req bit into pending[i] on the edge where it is sampled high; re-assertion while already pending has no further effect.
REQ-015 SHALL give set priority when req[i] is high on the same edge that pending[i] is cleared by acceptance.
REQ-016 SHALL implement states IDLE, ON, OFF, registered; all outputs SHALL come from registers.
REQ-017 In IDLE with pending nonzero, the next edge SHALL select the highest set index (sel), clear pending[sel], load beep_cnt=BEEPS_sel, tick_cnt=0, enter ON, and pulse ack[sel].
REQ-018 Latency: req high at edge k -> ack and buzz_enable high after edge k+1.
REQ-019 In ON, buzz_enable=1 and freq_select=TONE_sel; tick_cnt SHALL increment only on cycles with tick=1; at tick with tick_cnt==ON_TICKS-1, clear tick_cnt and enter OFF.
REQ-020 In OFF, buzz_enable=0 and freq_select holds TONE_sel; at tick with tick_cnt==OFF_TICKS-1, decrement beep_cnt; if the result is nonzero enter ON, else enter IDLE and pulse done.
REQ-021 With tick held low, state, counters and outputs SHALL hold indefinitely.
REQ-022 A pattern SHALL occupy exactly BEEPS_sel*(ON_TICKS+OFF_TICKS) tick strobes.
REQ-023 In IDLE, buzz_enable=0 and freq_select=0.
REQ-024 A pending request arriving during a pattern SHALL be served from IDLE after done, by priority; requests are never dropped except by reset or preemption (REQ-029).
REQ-025 A request for the currently active index SHALL set pending and replay the pattern after completion.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, pending=0, counters=0, buzz_enable=0, freq_select=0, ack=0, done=0, busy=0, regardless of clk.
REQ-027 Reset mid-pattern SHALL abandon the pattern with no done pulse; after release, operation SHALL resume from IDLE on the first edge.

Configuration
REQ-028 Macro BUZZER_PREEMPT_EN SHALL select the preemption feature.
REQ-029 With BUZZER_PREEMPT_EN defined: in ON or OFF, if pending holds an index higher than sel, the next edge SHALL perform the REQ-017 load for that index (ack pulsed, counters reset, enter ON); the preempted pattern SHALL be discarded, with no done and no requeue.
REQ-030 Without BUZZER_PREEMPT_EN: no preemption; higher-priority requests SHALL wait per REQ-024.

Verification
REQ-031 Defaults, tick=1: req=3'b001 one cycle -> ack[0] next cycle; buzz_enable high 4 cycles with freq_select=4, low 2 cycles, then done pulse and busy low.
REQ-032 Defaults, tick=1: req=3'b010 -> two beeps (4 on / 2 off, freq_select=8); done exactly 12 cycles after ack[1].
REQ-033 req=3'b101 same cycle -> ack[2] first, 3 beeps at 16 (18 cycles), done, then ack[0] next cycle and 1 beep at 4.
REQ-034 req[0] served, req[2] pulsed on 2nd ON cycle -> with macro: ack[2] next cycle, freq_select=16, no done for req[0]; without macro: req[0] completes, then req[2] runs.
REQ-035 tick pulsed every 3rd cycle, req[0] -> buzz_enable high for 12 clk cycles; tick held low mid-ON -> outputs frozen.
REQ-036 rst_n low mid-OFF with pending[1] set -> all outputs 0 asynchronously; after release, no ack and no beep without a new req.
